// File: rtl/pkg_ascii_bcd.sv
// Shared types and character constants for the ASCII <-> BCD receive path.
// Imported by the byte classifier and the decimal number parser.
package pkg_ascii_bcd;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      ACCUM   = 2'd1,
      DISCARD = 2'd2,
      HOLD    = 2'd3
   } parser_state_t;

   localparam logic [7:0] ASCII_0  = 8'h30;
   localparam logic [7:0] ASCII_9  = 8'h39;
   localparam logic [7:0] ASCII_CR = 8'h0D;
   localparam logic [7:0] ASCII_LF = 8'h0A;

   typedef logic [3:0] bcd_digit_t;

endpackage

// File: rtl/module_ascii_classify.sv
// Combinational ASCII byte classifier: decimal digit, line terminator, or other.
// Kept separate so other RX command parsers can share it.
module module_ascii_classify
   import pkg_ascii_bcd::*;
#(
   parameter logic [7:0] TERM_A = ASCII_CR,
   parameter logic [7:0] TERM_B = ASCII_LF
) (
   input  logic [7:0] rx_data,
   output logic       is_digit,
   output logic       is_term,
   output logic [3:0] digit_val
);

   assign is_digit  = (rx_data >= ASCII_0) && (rx_data <= ASCII_9);
   assign is_term   = (rx_data == TERM_A) || (rx_data == TERM_B);
   assign digit_val = rx_data[3:0];

endmodule

// File: rtl/module_ascii2bcd_parser.sv
// Parses CR/LF-terminated decimal numbers (up to MAX_DIGITS digits) from an
// ASCII byte stream into right-aligned BCD digits behind a valid/ready handshake.
module module_ascii2bcd_parser
   import pkg_ascii_bcd::*;
#(
   parameter logic [7:0] TERM_A     = 8'h0D,
   parameter logic [7:0] TERM_B     = 8'h0A,
   parameter int         MAX_DIGITS = 3
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [7:0] rx_data,
   input  logic       rx_valid,
   output logic       rx_ready,
   output logic [3:0] bcd_centenas,
   output logic [3:0] bcd_decenas,
   output logic [3:0] bcd_unidades,
   output logic       num_valid,
   input  logic       num_ready,
   output logic       err
);

   localparam logic [1:0] MAX_CNT = 2'(MAX_DIGITS);

   parser_state_t state_q, state_d;
   bcd_digit_t    cent_q, cent_d;
   bcd_digit_t    dec_q, dec_d;
   bcd_digit_t    uni_q, uni_d;
   logic [1:0]    count_q, count_d;
   logic          err_q, err_d;

   logic          is_digit;
   logic          is_term;
   logic [3:0]    digit_val;
   logic          rx_fire;

   module_ascii_classify #(
      .TERM_A (TERM_A),
      .TERM_B (TERM_B)
   ) u_classify (
      .rx_data   (rx_data),
      .is_digit  (is_digit),
      .is_term   (is_term),
      .digit_val (digit_val)
   );

   // Handshake outputs decode from registered state only, so neither rx_valid
   // nor num_ready has a combinational path to rx_ready.
   assign rx_ready     = (state_q != HOLD);
   assign num_valid    = (state_q == HOLD);
   assign rx_fire      = rx_valid && rx_ready;
   assign bcd_centenas = cent_q;
   assign bcd_decenas  = dec_q;
   assign bcd_unidades = uni_q;
   assign err          = err_q;

   always_comb begin
      state_d = state_q;
      cent_d  = cent_q;
      dec_d   = dec_q;
      uni_d   = uni_q;
      count_d = count_q;
      err_d   = 1'b0;
      case (state_q)
         IDLE, ACCUM: begin
            if (rx_fire) begin
               if (is_digit) begin
                  if (count_q < MAX_CNT) begin
                     cent_d  = dec_q;
                     dec_d   = uni_q;
                     uni_d   = digit_val;
                     count_d = count_q + 2'd1;
                     state_d = ACCUM;
                  end else begin
                     err_d   = 1'b1;
                     state_d = DISCARD;
                  end
               end else if (is_term) begin
                  // An empty line (or the LF of a CRLF pair) is silently absorbed.
                  if (count_q != 2'd0) begin
                     state_d = HOLD;
                  end
               end else begin
                  err_d   = 1'b1;
                  state_d = DISCARD;
               end
            end
         end
         DISCARD: begin
            if (rx_fire && is_term) begin
               cent_d  = '0;
               dec_d   = '0;
               uni_d   = '0;
               count_d = '0;
               state_d = IDLE;
            end
         end
         HOLD: begin
            if (num_ready) begin
               cent_d  = '0;
               dec_d   = '0;
               uni_d   = '0;
               count_d = '0;
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         cent_q  <= '0;
         dec_q   <= '0;
         uni_q   <= '0;
         count_q <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cent_q  <= cent_d;
         dec_q   <= dec_d;
         uni_q   <= uni_d;
         count_q <= count_d;
         err_q   <= err_d;
      end
   end

endmodule

// File: tb/tb_module_ascii2bcd_parser.sv
// Self-checking bench for module_ascii2bcd_parser: directed vector table,
// hand-written handshake/reset sequences, and random traffic against a model.
module tb_module_ascii2bcd_parser;

   logic       clk;
   logic       rst_n;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic       rx_ready;
   logic [3:0] bcd_centenas;
   logic [3:0] bcd_decenas;
   logic [3:0] bcd_unidades;
   logic       num_valid;
   logic       num_ready;
   logic       err;

   int checks = 0;
   int errors = 0;

   // Reference model: the number is kept as a plain integer value plus a digit count.
   bit m_hold;
   bit m_disc;
   bit m_err;
   int m_val;
   int m_nd;

   typedef struct {
      logic [7:0]  data;
      logic        valid;
      logic        nready;
      logic        exp_valid;
      logic        exp_err;
      logic [11:0] exp_bcd;
   } vec_t;

   vec_t vecs[$];

   module_ascii2bcd_parser dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .rx_data      (rx_data),
      .rx_valid     (rx_valid),
      .rx_ready     (rx_ready),
      .bcd_centenas (bcd_centenas),
      .bcd_decenas  (bcd_decenas),
      .bcd_unidades (bcd_unidades),
      .num_valid    (num_valid),
      .num_ready    (num_ready),
      .err          (err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #1000000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog");
   end

   task automatic modelReset();
      m_hold = 0;
      m_disc = 0;
      m_err  = 0;
      m_val  = 0;
      m_nd   = 0;
   endtask

   task automatic modelStep(input logic [7:0] d, input logic v, input logic nr);
      bit isd;
      bit ist;
      isd = (d >= 8'h30) && (d <= 8'h39);
      ist = (d == 8'h0D) || (d == 8'h0A);
      m_err = 0;
      if (m_hold) begin
         if (nr) begin
            m_hold = 0;
            m_val  = 0;
            m_nd   = 0;
         end
      end else if (v) begin
         if (m_disc) begin
            if (ist) begin
               m_disc = 0;
               m_val  = 0;
               m_nd   = 0;
            end
         end else if (isd) begin
            if (m_nd < 3) begin
               m_val = m_val * 10 + int'(d - 8'h30);
               m_nd++;
            end else begin
               m_err  = 1;
               m_disc = 1;
            end
         end else if (ist) begin
            if (m_nd >= 1) m_hold = 1;
         end else begin
            m_err  = 1;
            m_disc = 1;
         end
      end
   endtask

   function automatic logic [11:0] modelDigits();
      return {4'(m_val / 100), 4'((m_val / 10) % 10), 4'(m_val % 10)};
   endfunction

   task automatic applyStimulus(input logic [7:0] d, input logic v, input logic nr);
      @(negedge clk);
      rx_data   = d;
      rx_valid  = v;
      num_ready = nr;
      @(posedge clk);
      modelStep(d, v, nr);
      #1;
   endtask

   task automatic checkOutput(input string name, input logic ev, input logic ee,
                              input logic er, input logic [11:0] eb);
      logic [11:0] got;
      got = {bcd_centenas, bcd_decenas, bcd_unidades};
      checks++;
      if (num_valid !== ev) begin
         errors++;
         $display("[TB] FAIL %s num_valid got %0b want %0b", name, num_valid, ev);
      end
      checks++;
      if (err !== ee) begin
         errors++;
         $display("[TB] FAIL %s err got %0b want %0b", name, err, ee);
      end
      checks++;
      if (rx_ready !== er) begin
         errors++;
         $display("[TB] FAIL %s rx_ready got %0b want %0b", name, rx_ready, er);
      end
      checks++;
      if (got !== eb) begin
         errors++;
         $display("[TB] FAIL %s digits got %03h want %03h", name, got, eb);
      end
   endtask

   task automatic addVec(input logic [7:0] d, input logic v, input logic nr,
                         input logic ev, input logic ee, input logic [11:0] eb);
      vec_t t;
      t.data      = d;
      t.valid     = v;
      t.nready    = nr;
      t.exp_valid = ev;
      t.exp_err   = ee;
      t.exp_bcd   = eb;
      vecs.push_back(t);
   endtask

   initial begin
      logic [7:0] d;
      logic       v;
      logic       nr;
      int         r;

      rst_n     = 1'b0;
      rx_data   = 8'h00;
      rx_valid  = 1'b0;
      num_ready = 1'b0;
      modelReset();

      // "125"+CR
      addVec("1", 1, 1, 0, 0, 12'h001);
      addVec("2", 1, 1, 0, 0, 12'h012);
      addVec("5", 1, 1, 0, 0, 12'h125);
      addVec(8'h0D, 1, 1, 1, 0, 12'h125);
      addVec(8'h00, 0, 1, 0, 0, 12'h000);
      // "7"+CR+LF; LF is stalled during HOLD and then absorbed
      addVec("7", 1, 1, 0, 0, 12'h007);
      addVec(8'h0D, 1, 1, 1, 0, 12'h007);
      addVec(8'h0A, 1, 1, 0, 0, 12'h000);
      addVec(8'h0A, 1, 1, 0, 0, 12'h000);
      // "1a3"+CR then "42"+CR
      addVec("1", 1, 1, 0, 0, 12'h001);
      addVec("a", 1, 1, 0, 1, 12'h001);
      addVec("3", 1, 1, 0, 0, 12'h001);
      addVec(8'h0D, 1, 1, 0, 0, 12'h000);
      addVec("4", 1, 1, 0, 0, 12'h004);
      addVec("2", 1, 1, 0, 0, 12'h042);
      addVec(8'h0D, 1, 1, 1, 0, 12'h042);
      addVec(8'h00, 0, 1, 0, 0, 12'h000);
      // "1234"+CR then "9"+CR
      addVec("1", 1, 1, 0, 0, 12'h001);
      addVec("2", 1, 1, 0, 0, 12'h012);
      addVec("3", 1, 1, 0, 0, 12'h123);
      addVec("4", 1, 1, 0, 1, 12'h123);
      addVec(8'h0D, 1, 1, 0, 0, 12'h000);
      addVec("9", 1, 1, 0, 0, 12'h009);
      addVec(8'h0D, 1, 1, 1, 0, 12'h009);
      addVec(8'h00, 0, 1, 0, 0, 12'h000);

      #12;
      checkOutput("reset", 1'b0, 1'b0, 1'b1, 12'h000);
      @(negedge clk);
      rst_n = 1'b1;

      for (int i = 0; i < vecs.size(); i++) begin
         applyStimulus(vecs[i].data, vecs[i].valid, vecs[i].nready);
         checkOutput($sformatf("vec%0d", i), vecs[i].exp_valid, vecs[i].exp_err,
                     !vecs[i].exp_valid, vecs[i].exp_bcd);
      end

      // "360"+CR with the consumer stalled for five cycles
      applyStimulus("3", 1, 0);
      applyStimulus("6", 1, 0);
      applyStimulus("0", 1, 0);
      checkOutput("stall_pre", 1'b0, 1'b0, 1'b1, 12'h360);
      applyStimulus(8'h0D, 1, 0);
      checkOutput("stall_cr", 1'b1, 1'b0, 1'b0, 12'h360);
      for (int i = 0; i < 5; i++) begin
         applyStimulus("9", 1, 0);
         checkOutput($sformatf("stall%0d", i), 1'b1, 1'b0, 1'b0, 12'h360);
      end
      applyStimulus("9", 1, 1);
      checkOutput("stall_release", 1'b0, 1'b0, 1'b1, 12'h000);
      applyStimulus(8'h00, 0, 0);
      checkOutput("stall_after", 1'b0, 1'b0, 1'b1, 12'h000);

      // Reset in the middle of a number
      applyStimulus("8", 1, 1);
      checkOutput("mid_digit", 1'b0, 1'b0, 1'b1, 12'h008);
      @(negedge clk);
      rx_valid = 1'b0;
      rst_n    = 1'b0;
      #1;
      modelReset();
      checkOutput("mid_reset", 1'b0, 1'b0, 1'b1, 12'h000);
      repeat (2) @(negedge clk);
      checkOutput("mid_reset_hold", 1'b0, 1'b0, 1'b1, 12'h000);
      rst_n = 1'b1;
      applyStimulus("5", 1, 1);
      checkOutput("post_reset_5", 1'b0, 1'b0, 1'b1, 12'h005);
      applyStimulus(8'h0D, 1, 1);
      checkOutput("post_reset_cr", 1'b1, 1'b0, 1'b0, 12'h005);
      applyStimulus(8'h00, 0, 1);
      checkOutput("post_reset_done", 1'b0, 1'b0, 1'b1, 12'h000);

      // Random traffic against the reference model
      for (int i = 0; i < 1500; i++) begin
         r = $urandom_range(0, 99);
         if (r < 60)      d = 8'h30 + 8'($urandom_range(0, 9));
         else if (r < 75) d = ($urandom_range(0, 1) != 0) ? 8'h0D : 8'h0A;
         else if (r < 85) d = 8'h41 + 8'($urandom_range(0, 25));
         else             d = 8'($urandom_range(0, 255));
         v  = ($urandom_range(0, 9) < 8);
         nr = ($urandom_range(0, 1) != 0);
         applyStimulus(d, v, nr);
         checkOutput($sformatf("rand%0d", i), m_hold, m_err, !m_hold, modelDigits());
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
